// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU and host request ports plus the data-memory port of dmem_arbiter.
// The slave modport is the arbiter side. The master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Handshake: a requester raises req with wr/addr/wdata stable and holds it
  // until its ack. ack is a one-cycle pulse, and rdata is valid only while ack=1.
  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_wr, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_addr, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_wr, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_addr, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/host arbiter for the single-port data memory: IDLE -> ACCESS -> RESP, round-robin on ties.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority (no last-served register).
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic             clock,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic             busy,
  output logic [1:0]       grant,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [1:0]    r_grant;
  logic          r_op_wr;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_any_req;
  logic          w_pick_cpu;
  logic          w_start;
  logic          w_resp;

`ifndef DMEM_ARB_CPU_PRIO_EN
  logic          r_last_host;
`endif

  // Arbitration decision, only consumed in IDLE
  always_comb begin
    w_any_req = bus.cpu_req | bus.host_req;
`ifdef DMEM_ARB_CPU_PRIO_EN
    w_pick_cpu = bus.cpu_req;
`else
    w_pick_cpu = bus.cpu_req & (~bus.host_req | r_last_host);
`endif
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next  = ACCESS;
          w_start = 1'b1;
        end
      end
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Memory command registers are loaded on the IDLE->ACCESS edge and cleared entering RESP
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant     <= 2'b00;
      r_op_wr     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_grant     <= w_pick_cpu ? 2'b01 : 2'b10;
            r_op_wr     <= w_pick_cpu ? bus.cpu_wr    : bus.host_wr;
            r_mem_addr  <= w_pick_cpu ? bus.cpu_addr  : bus.host_addr;
            r_mem_wr    <= w_pick_cpu ? bus.cpu_wr    : bus.host_wr;
            r_mem_wdata <= w_pick_cpu ? bus.cpu_wdata : bus.host_wdata;
          end
        end
        ACCESS: begin
          r_mem_addr  <= '0;
          r_mem_wr    <= 1'b0;
          r_mem_wdata <= '0;
        end
        RESP: begin
          r_grant <= 2'b00;
          r_op_wr <= 1'b0;
        end
        default: begin
          r_grant     <= 2'b00;
          r_op_wr     <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wr    <= 1'b0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

`ifndef DMEM_ARB_CPU_PRIO_EN
  always_ff @(posedge clock) begin
    if (reset)        r_last_host <= 1'b1;
    else if (w_start) r_last_host <= ~w_pick_cpu;
  end
`endif

  always_comb begin
    w_resp         = (r_state == RESP);
    busy           = (r_state != IDLE);
    grant          = r_grant;
    o_dbg_state    = r_state;
    bus.mem_addr   = r_mem_addr;
    // Reset during ACCESS must suppress the write taken on that same edge
    bus.mem_wr     = r_mem_wr & ~reset;
    bus.mem_wdata  = r_mem_wdata;
    bus.cpu_ack    = w_resp & r_grant[0];
    bus.host_ack   = w_resp & r_grant[1];
    bus.cpu_rdata  = (bus.cpu_ack  & ~r_op_wr) ? bus.mem_rdata : '0;
    bus.host_rdata = (bus.host_ack & ~r_op_wr) ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the processor control unit (load/store path) and a host/debug port used for memory preload and inspection. Each requester presents a held request with address, write flag and write data. The arbiter grants one requester at a time, sequences a fixed three-state memory access, and returns a one-cycle acknowledge carrying read data. It sits between the controller's `d_addr`/`d_wr` path, the host port and the data memory instance.

## Interface
Parameters:
- `AW`, 8, data memory address width
- `DW`, 16, data word width

Ports:
- `clock`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`
- `cpu_wr`  in  1  1 = write, 0 = read; stable while `cpu_req`
- `cpu_addr`  in  AW  CPU address; stable while `cpu_req`
- `cpu_wdata`  in  DW  CPU write data; stable while `cpu_req`
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DW  read data, valid only while `cpu_ack`=1, else 0
- `host_req`, `host_wr`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`: host equivalents, same widths and rules
- `mem_addr`  out  AW  memory address (registered)
- `mem_wr`  out  1  memory write enable (registered)
- `mem_wdata`  out  DW  memory write data (registered)
- `mem_rdata`  in  DW  memory read data; synchronous read, valid the cycle after `mem_addr`
- `busy`  out  1  1 whenever state is not IDLE
- `grant`  out  2  one-hot owner: bit0 = CPU, bit1 = host; 00 in IDLE

## Operation
- States: IDLE, ACCESS, RESP. IDLE→ACCESS when any `req`=1; ACCESS→RESP unconditionally; RESP→IDLE unconditionally. No other transitions.
- Arbitration only in IDLE. One requester → it wins. Both → round-robin: grant the requester not served last. `last` register updates on every IDLE→ACCESS transition.
- On IDLE→ACCESS edge, the winner's `addr`, `wr`, `wdata` are captured into `mem_addr`, `mem_wr`, `mem_wdata`. These hold during ACCESS. They return to 0 on entering RESP and stay 0 in RESP and IDLE.
- Memory write occurs on the ACCESS→RESP edge.
- In RESP, the owner's `ack`=1. Its `rdata`=`mem_rdata` for reads and 0 for writes. The loser's `ack`=0 and `rdata`=0.
- `req` is ignored in ACCESS and RESP. A requester still asserting `req` in the cycle after its `ack` starts a new access. The loser of a tie keeps `req` high and is served on the next IDLE.
- Changing `addr`/`wr`/`wdata` while `req`=1 has no effect after capture.

## Timing
- Reset state: IDLE, `last`=host, so the CPU wins the first tie. All outputs are 0: `cpu_ack`, `host_ack`, `cpu_rdata`, `host_rdata`, `mem_addr`, `mem_wr`, `mem_wdata`, `busy`, `grant`.
- Latency: `req` seen in IDLE at cycle N, memory access in N+1, `ack` in N+2. Throughput is one access per 3 cycles. Back-to-back requests from the same requester repeat at N+3.
- `grant` is valid in ACCESS and RESP. `busy`=1 in ACCESS and RESP.
- Reset in ACCESS: state → IDLE, `mem_wr` → 0 on that edge, so no write occurs and no `ack` is issued.
- Reset in RESP: `ack` drops on that edge. The access counts as completed for memory but not for round-robin; `last` is reset.
- `reset` has priority over every transition.

## Configuration
- `DMEM_ARB_CPU_PRIO_EN` defined: fixed priority, CPU always wins a tie, and the `last` register is absent. The host can be starved by continuous CPU requests.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then `host_req`, `host_wr`=1, addr 0x10, data 0xBEEF → `mem_wr`=1 one cycle later at addr 0x10; `host_ack` in N+2; memory[0x10]=0xBEEF.
- CPU read of 0x10 after the above → `cpu_ack` at N+2 with `cpu_rdata`=0xBEEF; `host_ack`=0, `host_rdata`=0.
- Both request in the same cycle after reset, repeatedly → grants alternate CPU, host, CPU, host; each `ack` 3 cycles apart; the loser is never skipped.
- Same as above with `DMEM_ARB_CPU_PRIO_EN` defined and `cpu_req` held → host never granted; after `cpu_req` drops, host is granted on the next IDLE.
- CPU write 0x1234 to 0x20, `reset` asserted during ACCESS → no write (memory[0x20] unchanged), no `cpu_ack`, all outputs 0 the next cycle.
- Host changes `host_addr` from 0x05 to 0x06 during ACCESS → access uses 0x05; `grant`=10 and `busy`=1 for exactly 2 cycles.
